// File: rtl/remote_comm_if.sv
// remote_comm_if
//   Bundles the command and serial signals of the remote_comm link.
//   master : bench / host side (drives cmd, send_cmd, RX)
//   slave  : remote_comm itself (drives cmd_sent, TX, resp_rdy, resp)
//   cmd[15:0] command word, send_cmd one-cycle request, cmd_sent both bytes on line,
//   TX / RX 8N1 serial lines (idle high), resp_rdy byte valid, resp[7:0] last byte.
interface remote_comm_if;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent;
    logic        TX;
    logic        RX;
    logic        resp_rdy;
    logic [7:0]  resp;

    modport master (
        output cmd,
        output send_cmd,
        output RX,
        input  cmd_sent,
        input  TX,
        input  resp_rdy,
        input  resp
    );

    modport slave (
        input  cmd,
        input  send_cmd,
        input  RX,
        output cmd_sent,
        output TX,
        output resp_rdy,
        output resp
    );
endinterface

// File: rtl/remote_comm.sv
// remote_comm
//   Bench-side remote control link: serializes a 16-bit command as two UART
//   bytes (high byte first) on TX and reports every byte received on RX.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous reset, ACTIVE HIGH despite the name
//     bus   : remote_comm_if.slave (cmd, send_cmd, cmd_sent, TX, RX, resp_rdy, resp)
//   Parameter BAUD_DIV : clock cycles per UART bit (>= 4).
module remote_comm #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic          clk,
    input  logic          rst_n,
    remote_comm_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND_HI,
        SEND_LO
    } cmd_state_e;

    // command FSM
    cmd_state_e        state_q,    state_d;
    logic [7:0]        cmd_lo_q,   cmd_lo_d;
    logic              cmd_sent_q, cmd_sent_d;

    // transmitter
    logic              tx_q,       tx_d;
    logic              tx_busy_q,  tx_busy_d;
    logic [CNT_W-1:0]  tx_cnt_q,   tx_cnt_d;
    logic [3:0]        tx_bit_q,   tx_bit_d;
    logic [8:0]        tx_shift_q, tx_shift_d;

    // receiver
    logic              rx_meta_q,  rx_meta_d;
    logic              rx_sync_q,  rx_sync_d;
    logic              rx_prev_q,  rx_prev_d;
    logic              rx_busy_q,  rx_busy_d;
    logic [CNT_W-1:0]  rx_cnt_q,   rx_cnt_d;
    logic [3:0]        rx_bit_q,   rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic [7:0]        resp_q,     resp_d;
    logic              resp_rdy_q, resp_rdy_d;

    logic              accept;
    logic              tx_start;
    logic [7:0]        tx_byte;
    logic              tx_frame_end;
    logic              rx_start;
    logic              rx_stop;

    // ------------------------------------------------------------------
    // Command state machine
    // ------------------------------------------------------------------
    assign tx_frame_end = tx_busy_q && (tx_cnt_q == BAUD_LAST) && (tx_bit_q == 4'd9);

    always_comb begin
        state_d    = state_q;
        cmd_lo_d   = cmd_lo_q;
        cmd_sent_d = cmd_sent_q;
        accept     = 1'b0;
        tx_start   = 1'b0;
        tx_byte    = '0;
        case (state_q)
            IDLE: begin
                if (bus.send_cmd) begin
                    accept     = 1'b1;
                    cmd_lo_d   = bus.cmd[7:0];
                    cmd_sent_d = 1'b0;
                    tx_start   = 1'b1;
                    tx_byte    = bus.cmd[15:8];
                    state_d    = SEND_HI;
                end
            end
            SEND_HI: begin
                // low byte starts on the same edge the high stop bit ends: no idle gap
                if (tx_frame_end) begin
                    tx_start = 1'b1;
                    tx_byte  = cmd_lo_q;
                    state_d  = SEND_LO;
                end
            end
            SEND_LO: begin
                if (tx_frame_end) begin
                    cmd_sent_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Transmitter: tx_q is the line itself; tx_shift_q holds the bits
    // still to be sent (data LSB first, stop bit on top).
    // ------------------------------------------------------------------
    always_comb begin
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        if (tx_busy_q) begin
            if (tx_cnt_q == BAUD_LAST) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                    tx_d      = 1'b1;
                end else begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b1, tx_shift_q[8:1]};
                    tx_bit_d   = tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
        end
        if (tx_start) begin
            tx_busy_d  = 1'b1;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_d       = 1'b0;
            tx_shift_d = {1'b1, tx_byte};
        end
    end

    // ------------------------------------------------------------------
    // Receiver: sample index 0 = start-bit centre, 1..8 data, 9 stop.
    // ------------------------------------------------------------------
    always_comb begin
        rx_meta_d  = bus.RX;
        rx_sync_d  = rx_meta_q;
        rx_prev_d  = rx_sync_q;
        rx_busy_d  = rx_busy_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        resp_d     = resp_q;
        rx_stop    = 1'b0;
        rx_start   = !rx_busy_q && rx_prev_q && !rx_sync_q;
        if (rx_start) begin
            rx_busy_d = 1'b1;
            rx_cnt_d  = HALF_LAST;
            rx_bit_d  = '0;
        end else if (rx_busy_q) begin
            if (rx_cnt_q == '0) begin
                rx_cnt_d = BAUD_LAST;
                rx_bit_d = rx_bit_q + 4'd1;
                if (rx_bit_q == 4'd9) begin
                    // stop-bit value deliberately ignored: framing errors still deliver
                    rx_busy_d = 1'b0;
                    resp_d    = rx_shift_q;
                    rx_stop   = 1'b1;
                end else if (rx_bit_q != 4'd0) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                end
            end else begin
                rx_cnt_d = rx_cnt_q - CNT_W'(1);
            end
        end
    end

    // set has priority over both clear sources
    always_comb begin
        resp_rdy_d = resp_rdy_q;
        if (accept || rx_start) resp_rdy_d = 1'b0;
        if (rx_stop)            resp_rdy_d = 1'b1;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= IDLE;
            cmd_lo_q   <= '0;
            cmd_sent_q <= 1'b0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_lo_q   <= cmd_lo_d;
            cmd_sent_q <= cmd_sent_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rx_prev_d;
            rx_busy_q  <= rx_busy_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
        end
    end

    assign bus.TX       = tx_q;
    assign bus.cmd_sent = cmd_sent_q;
    assign bus.resp_rdy = resp_rdy_q;
    assign bus.resp     = resp_q;

endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm
//   Scoreboard bench for remote_comm with BAUD_DIV = 16. Stimulus pushes
//   expected TX bytes / response bytes into queues; independent monitors
//   decode TX and watch resp_rdy, popping and comparing.
module tb_remote_comm;
    localparam int unsigned B = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    remote_comm_if bus();

    remote_comm #(.BAUD_DIV(B)) dut (
        .clk   (clk),
        .rst_n (rst),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_rx[$];
    int unsigned rx_fall_cyc = 0;
    bit          chk_rx_lat  = 1'b0;
    int          sent_rises  = 0;

    always begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- TX monitor: bench UART decoder ----------------
    logic       tx_prev = 1'b1;
    logic [9:0] frame;
    bit         tx_abort;
    always begin
        @(negedge clk);
        if (!rst && tx_prev && !bus.TX) begin
            tx_abort = 1'b0;
            for (int b = 0; b < 10; b++) begin
                for (int k = 0; k < ((b == 0) ? 7 : 16); k++) begin
                    @(negedge clk);
                    if (rst) tx_abort = 1'b1;
                end
                frame[b] = bus.TX;
            end
            if (!tx_abort) begin
                check("tx_framing", {30'd0, frame[9], frame[0]}, 32'd2);
                if (exp_tx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected_byte: got %0h expected none", frame[8:1]);
                end else begin
                    check("tx_byte", {24'd0, frame[8:1]}, {24'd0, exp_tx.pop_front()});
                end
            end
        end
        tx_prev = bus.TX;
    end

    // ---------------- response / cmd_sent monitor ----------------
    logic rdy_prev  = 1'b0;
    logic sent_prev = 1'b0;
    always begin
        @(negedge clk);
        if (!rst && bus.resp_rdy && !rdy_prev) begin
            if (exp_rx.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected: got %0h expected none", bus.resp);
            end else begin
                check("resp_byte", {24'd0, bus.resp}, {24'd0, exp_rx.pop_front()});
            end
            if (chk_rx_lat) begin
                check_range("resp_latency", int'(cyc - rx_fall_cyc), 152, 155);
                chk_rx_lat = 1'b0;
            end
        end
        rdy_prev = bus.resp_rdy;
        if (!rst && bus.cmd_sent && !sent_prev) sent_rises++;
        sent_prev = bus.cmd_sent;
    end

    // ---------------- stimulus tasks (called at a negedge) ----------------
    task automatic run_cmd(input logic [15:0] c, input bit inject_busy);
        int n;
        exp_tx.push_back(c[15:8]);
        exp_tx.push_back(c[7:0]);
        bus.cmd      = c;
        bus.send_cmd = 1'b1;
        @(negedge clk);
        n            = 1;
        bus.send_cmd = 1'b0;
        bus.cmd      = ~c;
        check("cmd_sent_cleared", {31'd0, bus.cmd_sent}, 32'd0);
        check("tx_start_bit", {31'd0, bus.TX}, 32'd0);
        while (!bus.cmd_sent && n < 400) begin
            @(negedge clk);
            n++;
            bus.send_cmd = (inject_busy && n == 50);
            if (inject_busy && n == 50) bus.cmd = 16'hFFFF;
        end
        check_range("cmd_sent_latency", n, 321, 323);
        repeat (4) @(negedge clk);
        check("cmd_sent_held", {31'd0, bus.cmd_sent}, 32'd1);
    endtask

    task automatic drive_rx(input logic [7:0] b, input bit lat);
        exp_rx.push_back(b);
        rx_fall_cyc = cyc;
        chk_rx_lat  = lat;
        bus.RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.RX = b[i];
            repeat (B) @(negedge clk);
        end
        bus.RX = 1'b1;
        repeat (B) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    int   rises_before;
    logic tx_low;
    initial begin
        bus.cmd      = '0;
        bus.send_cmd = 1'b0;
        bus.RX       = 1'b1;
        rst          = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_state", {21'd0, bus.TX, bus.cmd_sent, bus.resp_rdy, bus.resp},
              {21'd0, 1'b1, 1'b0, 1'b0, 8'h00});
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // calibrate command
        run_cmd(16'h2000, 1'b0);
        repeat (20) @(negedge clk);

        // response with latency check
        drive_rx(8'hA5, 1'b1);
        check("resp_after_rx", {23'd0, bus.resp_rdy, bus.resp}, {23'd0, 1'b1, 8'hA5});

        // busy rejection; its accept also clears resp_rdy
        rises_before = sent_rises;
        run_cmd(16'h4321, 1'b1);
        check("resp_rdy_cleared_by_send", {23'd0, bus.resp_rdy, bus.resp}, {23'd0, 1'b0, 8'hA5});
        repeat (400) @(negedge clk);
        check("cmd_sent_rises_once", sent_rises - rises_before, 1);
        check("tx_queue_after_busy", exp_tx.size(), 0);

        // full duplex
        fork
            run_cmd(16'h8C3A, 1'b0);
            drive_rx(8'h5A, 1'b0);
        join
        repeat (20) @(negedge clk);
        check("duplex_resp", {23'd0, bus.resp_rdy, bus.resp}, {23'd0, 1'b1, 8'h5A});

        // back-to-back responses
        fork
            begin
                drive_rx(8'h5A, 1'b0);
                drive_rx(8'hC3, 1'b0);
            end
            begin
                repeat (158) @(negedge clk);
                check("b2b_first", {23'd0, bus.resp_rdy, bus.resp}, {23'd0, 1'b1, 8'h5A});
                repeat (10) @(negedge clk);
                check("b2b_drop_at_start", {23'd0, bus.resp_rdy, bus.resp}, {23'd0, 1'b0, 8'h5A});
            end
        join
        repeat (4) @(negedge clk);
        check("b2b_final", {23'd0, bus.resp_rdy, bus.resp}, {23'd0, 1'b1, 8'hC3});

        // reset mid-frame
        bus.cmd      = 16'h1234;
        bus.send_cmd = 1'b1;
        @(negedge clk);
        bus.send_cmd = 1'b0;
        repeat (60) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("reset_mid_frame", {21'd0, bus.TX, bus.cmd_sent, bus.resp_rdy, bus.resp},
              {21'd0, 1'b1, 1'b0, 1'b0, 8'h00});
        @(negedge clk);
        rst    = 1'b0;
        tx_low = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!bus.TX) tx_low = 1'b1;
        end
        check("tx_idle_after_reset", {31'd0, tx_low}, 32'd0);
        check("outputs_idle_after_reset", {30'd0, bus.cmd_sent, bus.resp_rdy}, 32'd0);
        check("scoreboard_drained", exp_tx.size() + exp_rx.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/remote_comm.md
# remote_comm

Bench-side remote control link for the Knight's Tour robot. It accepts a 16-bit command word and serializes it as two UART bytes on `TX`, high byte first. It then reports each response byte the robot returns on `RX`. It stands in for the Bluetooth/phone side of the system in full-chip simulation and contains its own UART transmitter and receiver.

## Interface
- `BAUD_DIV`, default 2604: clock cycles per UART bit. It must be ≥ 4.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-high reset. The name is kept for integration, but a level of 1 resets the block.
- `cmd`, input, 16: command word. It is sampled only in the cycle where `send_cmd` is accepted.
- `send_cmd`, input, 1: one-cycle request to transmit `cmd`.
- `cmd_sent`, output, 1: high once both bytes of the last command are fully on the line.
- `TX`, output, 1: serial out, 8N1, LSB first, idles high.
- `RX`, input, 1: serial in, 8N1, LSB first, idles high, asynchronous to `clk`.
- `resp_rdy`, output, 1: a response byte is valid on `resp`.
- `resp`, output, 8: last received byte.

## Operation
- Command state machine has three states: IDLE, SEND_HI, SEND_LO.
  - IDLE, when `send_cmd`=1: latch `cmd`, clear `cmd_sent`, start the frame for `cmd[15:8]`, go to SEND_HI.
  - SEND_HI, when the frame completes: start the frame for the latched `cmd[7:0]`, go to SEND_LO.
  - SEND_LO, when the frame completes: set `cmd_sent`, go to IDLE.
- `send_cmd` is ignored in SEND_HI and SEND_LO. Changes to `cmd` after acceptance have no effect.
- `cmd_sent` stays high until the next accepted `send_cmd`.
- Transmitter frame: start bit 0, then data bits 0 to 7, then stop bit 1. Each bit lasts exactly `BAUD_DIV` cycles.
- Receiver behaviour:
  - `RX` passes through a 2-flop synchronizer. Both flops reset to 1.
  - A falling edge while idle starts reception. The first sample is taken `BAUD_DIV/2` cycles later, at start-bit centre.
  - Subsequent samples are taken every `BAUD_DIV` cycles: 8 data bits shifted in LSB first, then the stop bit.
  - At the stop-bit sample, `resp` is loaded and `resp_rdy` is set.
  - The stop-bit value is not checked. A byte with a framing error is still delivered.
- `resp_rdy` clears in two cases:
  - on an accepted `send_cmd`;
  - on detection of the next start bit.
- If both a set and a clear of `resp_rdy` occur in the same cycle, set wins.
- `resp` holds its value until the next completed byte.
- Transmit and receive are fully independent. A response may arrive while a command is being sent.

## Timing
- Reset values: `TX`=1, `cmd_sent`=0, `resp_rdy`=0, `resp`=8'h00. The state machine resets to IDLE and the receiver to idle.
- Reset during operation aborts any frame. `TX` returns to 1 asynchronously.
- `send_cmd` is sampled at edge N, and `TX` falls in the cycle after edge N.
- The high-byte frame occupies `10*BAUD_DIV` cycles.
- The low-byte start bit begins within 1 cycle after the high-byte stop bit ends. No extra idle gap is allowed.
- `cmd_sent` rises within 1 cycle after the low-byte stop bit ends. Total time from `send_cmd` is 20·`BAUD_DIV` + at most 3 cycles.
- `resp_rdy` rises 9.5·`BAUD_DIV` + at most 3 cycles after the `RX` falling edge. The 3 cycles allow for synchronizer and register latency.
- Back-to-back `send_cmd` is legal:
  - A request in the same cycle that `cmd_sent` rises is ignored.
  - A request in the next cycle or later is accepted.

## Test plan
Use `BAUD_DIV`=16 in all scenarios.
- Reset:
  - Assert reset mid-frame → `TX`=1, `cmd_sent`=0, `resp_rdy`=0, `resp`=00 immediately.
  - After release, `TX` stays 1 with no spurious frame.
- Calibrate command:
  - Pulse `send_cmd` with `cmd`=16'h2000 → `TX` carries bytes 0x20 then 0x00, decoded by a bench UART model.
  - `cmd_sent` rises about 320 cycles later and stays high.
- Response:
  - Drive byte 0xA5 on `RX` (positive ack) → `resp_rdy`=1 and `resp`=0xA5 about 152 cycles after the start edge.
  - `resp_rdy` clears on the next `send_cmd`.
- Busy rejection:
  - Send 16'h4321, then pulse `send_cmd` with 16'hFFFF mid-transfer → only 0x43, 0x21 appear.
  - `cmd_sent` rises once.
- Full duplex:
  - Send 16'h8C3A while receiving 0x5A → both complete correctly.
- Back-to-back responses:
  - Send 0x5A then 0xC3 on `RX` with no idle gap → `resp_rdy` drops at the second start bit.
  - `resp` ends at 0xC3.
